// File: rtl/port_alloc_rr_pkg.sv
// Shared constants for the router port allocator: default switch size, port
// index width and the "no port" code used by the downstream outSel translators.
package port_alloc_rr_pkg;
  localparam int DEF_NUM_CHANNEL = 5;
  localparam int LOG_NUM_PORT    = 3;
  localparam logic [LOG_NUM_PORT-1:0] NO_PORT = 3'd7;
endpackage

// File: rtl/port_alloc_rr_first_free.sv
// Combinational picker: one-hot lowest-index port that is requested and not yet taken.
module rr_first_free #(
  parameter int N = 5
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] taken,
  output logic [N-1:0] grant
);
  logic [N-1:0] avail;

  assign avail = req & ~taken;
  // Two's-complement trick isolates the lowest set bit.
  assign grant = avail & (~avail + N'(1));
endmodule

// File: rtl/port_alloc_rr.sv
// Registered round-robin output-port allocator: productive pass, then deflection pass.
// Optional deflection statistics counter built when DEFLECT_STAT_EN is defined.
module port_alloc_rr
  import port_alloc_rr_pkg::*;
#(
  parameter int NUM_CHANNEL = DEF_NUM_CHANNEL,
  parameter int PTR_W       = LOG_NUM_PORT,
  parameter int CNT_W       = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               hold,
  input  logic [NUM_CHANNEL-1:0]             req_valid,
  input  logic [NUM_CHANNEL*NUM_CHANNEL-1:0] req_vec,
  output logic [NUM_CHANNEL*NUM_CHANNEL-1:0] alloc,
  output logic [NUM_CHANNEL-1:0]             alloc_valid,
  output logic [PTR_W-1:0]                   prio_ptr,
  output logic [CNT_W-1:0]                   deflect_cnt
);
  localparam int N = NUM_CHANNEL;

  logic [N-1:0]     req_arr    [N];
  logic [PTR_W-1:0] pos_idx    [N];
  logic [N-1:0]     grant_pos  [N];
  logic [N-1:0]     next_slice [N];
  logic [N-1:0]     defl_pos;
  logic [N*N-1:0]   next_alloc;
  logic [N-1:0]     next_valid;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign req_arr[i] = req_vec[i*N +: N];
  end

  // Position k in the visiting order holds input (prio_ptr + k) mod N.
  // The taken mask ripples through positions: pass 1 first, then pass 2
  // continues from whatever pass 1 left taken.
  for (genvar k = 0; k < N; k++) begin : g_pos
    logic [PTR_W:0] pos_sum;
    logic [N-1:0]   p1_req, p1_in, p1_grant;
    logic [N-1:0]   p2_req, p2_in, p2_grant;
    logic           in_valid;

    assign pos_sum    = {1'b0, prio_ptr} + (PTR_W+1)'(k);
    assign pos_idx[k] = (pos_sum >= (PTR_W+1)'(N)) ? PTR_W'(pos_sum - (PTR_W+1)'(N))
                                                   : pos_sum[PTR_W-1:0];
    assign in_valid   = req_valid[pos_idx[k]];

    if (k == 0) begin : g_first
      assign p1_in = '0;
      assign p2_in = g_pos[N-1].p1_in | g_pos[N-1].p1_grant;
    end else begin : g_next
      assign p1_in = g_pos[k-1].p1_in | g_pos[k-1].p1_grant;
      assign p2_in = g_pos[k-1].p2_in | g_pos[k-1].p2_grant;
    end

    assign p1_req = in_valid ? req_arr[pos_idx[k]] : '0;
    assign p2_req = (in_valid && p1_grant == '0) ? '1 : '0;

    rr_first_free #(.N(N)) u_pass1 (.req(p1_req), .taken(p1_in), .grant(p1_grant));
    rr_first_free #(.N(N)) u_pass2 (.req(p2_req), .taken(p2_in), .grant(p2_grant));

    assign grant_pos[k] = p1_grant | p2_grant;
    assign defl_pos[k]  = |p2_grant;
  end

  always_comb begin
    for (int i = 0; i < N; i++) next_slice[i] = '0;
    for (int k = 0; k < N; k++) next_slice[pos_idx[k]] = grant_pos[k];
  end

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign next_alloc[i*N +: N] = next_slice[i];
    assign next_valid[i]        = |next_slice[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alloc       <= '0;
      alloc_valid <= '0;
      prio_ptr    <= '0;
    end else if (!hold) begin
      alloc       <= next_alloc;
      alloc_valid <= next_valid;
      if (|req_valid)
        prio_ptr <= (prio_ptr == PTR_W'(N-1)) ? '0 : prio_ptr + PTR_W'(1);
    end
  end

`ifdef DEFLECT_STAT_EN
  logic [CNT_W:0] cnt_sum;

  assign cnt_sum = {1'b0, deflect_cnt} + (CNT_W+1)'($countones(defl_pos));

  always_ff @(posedge clk) begin
    if (reset)
      deflect_cnt <= '0;
    else if (!hold)
      deflect_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end
`else
  logic unused_defl;

  assign unused_defl = ^defl_pos;
  assign deflect_cnt = '0;
`endif
endmodule

// File: tb/tb_port_alloc_rr.sv
// Scoreboard bench for port_alloc_rr: directed vectors push expected state,
// a monitor pops and compares one cycle-result per clock.
module tb_port_alloc_rr;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic [4:0]  req_valid = '0;
  logic [24:0] req_vec = '0;
  logic [24:0] alloc;
  logic [4:0]  alloc_valid;
  logic [2:0]  prio_ptr;
  logic [15:0] deflect_cnt;

  typedef struct {
    logic [24:0] a;
    logic [4:0]  av;
    logic [2:0]  p;
    logic [15:0] c;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;

  localparam logic [4:0] Z = 5'b00000;

  port_alloc_rr dut (
    .clk(clk), .reset(reset), .hold(hold), .req_valid(req_valid), .req_vec(req_vec),
    .alloc(alloc), .alloc_valid(alloc_valid), .prio_ptr(prio_ptr), .deflect_cnt(deflect_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] pk(input logic [4:0] s0, s1, s2, s3, s4);
    return {s4, s3, s2, s1, s0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, want);
    end
  endtask

  task automatic step(input logic rst, input logic hld, input logic [4:0] v,
                      input logic [24:0] vec, input logic [24:0] ea,
                      input logic [4:0] eav, input logic [2:0] ep, input int dinc);
    exp_t e;
    @(negedge clk);
    reset = rst; hold = hld; req_valid = v; req_vec = vec;
    @(posedge clk);
    if (rst) exp_cnt = 0;
    else if (!hld) exp_cnt = exp_cnt + dinc;
    e.a = ea; e.av = eav; e.p = ep;
`ifdef DEFLECT_STAT_EN
    e.c = 16'(exp_cnt);
`else
    e.c = 16'd0;
`endif
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("alloc",       32'(alloc),       32'(e.a));
        chk("alloc_valid", 32'(alloc_valid), 32'(e.av));
        chk("prio_ptr",    32'(prio_ptr),    32'(e.p));
        chk("deflect_cnt", 32'(deflect_cnt), 32'(e.c));
      end
    end
  end

  initial begin : stim
    logic [24:0] all_p4;
    logic [24:0] a_full;
    int          waited;
    all_p4 = pk(5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000);
    a_full = pk(5'b01000, 5'b10000, 5'b00001, 5'b00010, 5'b00100);

    step(1, 0, Z, '0, '0, Z, 0, 0);
    step(1, 0, 5'b00011, pk(5'b00100, 5'b00100, Z, Z, Z), '0, Z, 0, 0);
    // single productive request
    step(0, 0, 5'b00001, pk(5'b00100, Z, Z, Z, Z), pk(5'b00100, Z, Z, Z, Z), 5'b00001, 1, 0);
    // contention with ptr=1: input 1 wins port 2, input 0 deflected to port 0
    step(0, 0, 5'b00011, pk(5'b00100, 5'b00100, Z, Z, Z), pk(5'b00001, 5'b00100, Z, Z, Z), 5'b00011, 2, 1);
    // valid input with empty request vector only granted by deflection
    step(0, 0, 5'b00100, '0, pk(Z, Z, 5'b00001, Z, Z), 5'b00100, 3, 1);
    // no valid inputs: garbage req_vec ignored, pointer holds
    step(0, 0, Z, pk(5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111), '0, Z, 3, 0);
    step(0, 0, 5'b11000, pk(Z, Z, Z, 5'b00011, 5'b00010), pk(Z, Z, Z, 5'b00001, 5'b00010), 5'b11000, 4, 0);
    step(0, 0, 5'b10000, pk(Z, Z, Z, Z, 5'b01000), pk(Z, Z, Z, Z, 5'b01000), 5'b10000, 0, 0);
    // contention with ptr=0: input 0 wins port 2
    step(0, 0, 5'b00011, pk(5'b00100, 5'b00100, Z, Z, Z), pk(5'b00100, 5'b00001, Z, Z, Z), 5'b00011, 1, 1);
    // all inputs want port 4, ptr=1
    step(0, 0, 5'b11111, all_p4, a_full, 5'b11111, 2, 4);
    // hold freezes everything despite changing inputs
    step(0, 1, 5'b00001, pk(5'b00001, Z, Z, Z, Z), a_full, 5'b11111, 2, 0);
    step(0, 1, 5'b01010, pk(Z, 5'b00010, Z, 5'b01000, Z), a_full, 5'b11111, 2, 0);
    step(0, 1, Z, '0, a_full, 5'b11111, 2, 0);
    // release resumes from ptr=2
    step(0, 0, 5'b11111, all_p4, pk(5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00010), 5'b11111, 3, 4);
    // reset beats hold while alloc is non-zero
    step(1, 1, 5'b11111, all_p4, '0, Z, 0, 0);
    step(0, 0, 5'b00001, pk(5'b00100, Z, Z, Z, Z), pk(5'b00100, Z, Z, Z, Z), 5'b00001, 1, 0);
    step(0, 0, Z, '0, '0, Z, 1, 0);

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
